uart_rx_deser_frame: RTL

Parametrised UART receive deserializer that replaces the fixed 8-bit shift register. It collects a frame of runtime-selectable length (5..DATA_WIDTH bits) from the oversampling bit sampler, LSB- or MSB-first. It optionally checks a parity bit, then presents the word in a holding register with a valid/ready handshake toward the RX controller/FIFO. It sits between the RX bit sampler (sampled_bit, bit_strobe) and the RX frame FSM (frame_start, frame_abort).

---
 rtl/uart_rx_deser_frame.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deser_frame.sv
// UART receive deserializer: collects a frame of 5..DATA_WIDTH data bits,
// LSB- or MSB-first, checks an optional parity bit, and holds the word in a
// valid/ready holding register for the RX controller/FIFO.
module uart_rx_deser_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sampled_bit,
  input  logic                  bit_strobe,
  input  logic                  frame_start,
  input  logic                  frame_abort,
  input  logic [CNT_WIDTH-1:0]  data_len,
  input  logic                  msb_first,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MIN_LEN = CNT_WIDTH'(5);
  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  // Even parity over a word (unused MSBs are zero, so they do not contribute)
  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction

  // Bound the requested length to the supported range
  function automatic logic [CNT_WIDTH-1:0] clamp_len_f(input logic [CNT_WIDTH-1:0] len);
    if (len < MIN_LEN) begin
      return MIN_LEN;
    end else if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]    cnt_r, cnt_nxt_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_nxt_s, shift_upd_s;
  logic [CNT_WIDTH-1:0]    len_r;
  logic                    msb_r, par_en_r, par_odd_r;
  logic [CNT_WIDTH-1:0]    pos_s;
  logic                    last_s;
  logic                    commit_s;
  logic [DATA_WIDTH-1:0]   commit_data_s;
  logic                    commit_perr_s;
  logic                    load_cfg_s;
  logic [DATA_WIDTH-1:0]   p_data_r;
  logic                    valid_r, par_err_r, overrun_r, busy_r;

  // Next-state, shift-register update and commit decode
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    shift_nxt_s   = shift_r;
    shift_upd_s   = shift_r;
    commit_s      = 1'b0;
    commit_data_s = shift_r;
    commit_perr_s = 1'b0;
    load_cfg_s    = 1'b0;
    // MSB-first places the first bit at len-1 and walks down to 0
    if (msb_r) begin
      pos_s = len_r - ONE_CNT - cnt_r;
    end else begin
      pos_s = cnt_r;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (pos_s == CNT_WIDTH'(i)) begin
        shift_upd_s[i] = sampled_bit;
      end else begin
        shift_upd_s[i] = shift_r[i];
      end
    end
    last_s = (cnt_r == (len_r - ONE_CNT));

    if (frame_start) begin
      // Start (or restart) wins over a coincident strobe or abort
      state_nxt_s = ST_SHIFT;
      cnt_nxt_s   = '0;
      shift_nxt_s = '0;
      load_cfg_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_SHIFT: begin
          if (frame_abort) begin
            state_nxt_s = ST_IDLE;
          end else if (bit_strobe) begin
            shift_nxt_s = shift_upd_s;
            cnt_nxt_s   = cnt_r + ONE_CNT;
            if (!last_s) begin
              state_nxt_s = ST_SHIFT;
            end else if (par_en_r) begin
              state_nxt_s = ST_PARITY;
            end else begin
              state_nxt_s   = ST_IDLE;
              commit_s      = 1'b1;
              commit_data_s = shift_upd_s;
              commit_perr_s = 1'b0;
            end
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
        ST_PARITY: begin
          if (frame_abort) begin
            state_nxt_s = ST_IDLE;
          end else if (bit_strobe) begin
            state_nxt_s   = ST_IDLE;
            commit_s      = 1'b1;
            commit_data_s = shift_r;
            commit_perr_s = parity_f(shift_r) ^ sampled_bit ^ par_odd_r;
          end else begin
            state_nxt_s = ST_PARITY;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Frame state, bit counter and shift register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Per-frame configuration, frozen for the rest of the frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_r     <= MIN_LEN;
      msb_r     <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
    end else if (load_cfg_s) begin
      len_r     <= clamp_len_f(data_len);
      msb_r     <= msb_first;
      par_en_r  <= par_en;
      par_odd_r <= par_odd;
    end
  end

  // Holding register with valid/ready handshake and overrun detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_data_r  <= '0;
      valid_r   <= 1'b0;
      par_err_r <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r    <= (state_nxt_s != ST_IDLE);
      overrun_r <= commit_s & valid_r & ~data_ready;
      if (commit_s && (!valid_r || data_ready)) begin
        p_data_r  <= commit_data_s;
        par_err_r <= commit_perr_s;
        valid_r   <= 1'b1;
      end else if (valid_r && data_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign P_DATA     = p_data_r;
  assign data_valid = valid_r;
  assign par_err    = par_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule
